// File: rtl/wts_wave_ram_pkg.sv
// Shared definitions for the multi-channel wave-table RAM: size derivations,
// channel/index address composition and the controller state encoding.
package wts_wave_ram_pkg;

  localparam int unsigned CH_W      = 4;
  localparam int unsigned IDX_W_MAX = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int unsigned calc_depth(input int unsigned ch_num,
                                             input int unsigned wave_bits);
    return ch_num << wave_bits;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Channels occupy contiguous 2**wave_bits word blocks.
  function automatic logic [31:0] compose_addr(input logic [CH_W-1:0]      ch,
                                               input logic [IDX_W_MAX-1:0] idx,
                                               input int unsigned          wave_bits);
    return (32'(ch) << wave_bits) | 32'(idx);
  endfunction

endpackage

// File: rtl/wts_wave_ram_array.sv
// Single-port synchronous RAM with registered read; shaped for block-RAM
// inference (no reset on the storage or the read register).
module wts_wave_ram_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_d;
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wts_wave_ram.sv
// Multi-channel wave-table RAM shared by a CPU req/ack port and a fixed-latency
// playback port. Build with WTS_WAVE_RAM_CLEAR_EN to zero the array after reset.
module wts_wave_ram
  import wts_wave_ram_pkg::*;
#(
  parameter int unsigned CH_NUM       = 5,
  parameter int unsigned WAVE_BITS    = 7,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [CH_W-1:0]      cpu_ch,
  input  logic [WAVE_BITS-1:0] cpu_idx,
  input  logic [DATA_W-1:0]    cpu_d,
  output logic                 cpu_ack,
  output logic [DATA_W-1:0]    cpu_q,
  input  logic                 play_en,
  input  logic [CH_W-1:0]      play_ch,
  input  logic [WAVE_BITS-1:0] play_idx,
  output logic [DATA_W-1:0]    play_q,
  output logic                 play_valid,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int unsigned DEPTH    = calc_depth(CH_NUM, WAVE_BITS);
  localparam int unsigned ADDR_W   = calc_addr_w(DEPTH);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
  logic                w_sweep, w_run;

  logic                r_done;
  logic [STARVE_W-1:0] r_starve;
  logic                w_cpu_pend, w_cpu_oor, w_play_oor;
  logic                w_play_win, w_cpu_win;
  logic [ADDR_W-1:0]   w_cpu_addr, w_play_addr;

  logic                w_ram_en, w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_d, w_ram_q;

  logic                r_cpu_ack, r_cpu_rd, r_cpu_zero;
  logic                r_play_valid, r_play_zero;
  logic [DATA_W-1:0]   r_cpu_q, r_play_q;

`ifdef WTS_WAVE_RAM_CLEAR_EN
  localparam state_t RST_STATE = ST_CLEAR;
  logic r_arm;

  // The sweep starts on the first edge after release so every output reads 0 in reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_arm <= 1'b0;
    else         r_arm <= 1'b1;
  end

  assign w_sweep = (r_state == ST_CLEAR) & r_arm;
`else
  localparam state_t RST_STATE = ST_RUN;
  assign w_sweep = 1'b0;
`endif

  assign w_run     = (r_state == ST_RUN);
  assign busy      = w_sweep;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= RST_STATE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    if (w_sweep) begin
      w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
      if (r_clr_addr == LAST_ADDR) begin
        w_state_nxt    = ST_RUN;
        w_clr_addr_nxt = '0;
      end
    end
  end

  // CPU handshake: cpu_req is a level held with its fields until cpu_ack pulses;
  // r_done marks it served until cpu_req drops, so a lingering req is not replayed.
  assign w_cpu_oor  = (32'(cpu_ch) >= CH_NUM);
  assign w_play_oor = (32'(play_ch) >= CH_NUM);
  assign w_cpu_pend = cpu_req & ~r_done;
  assign w_play_win = w_run & play_en & (r_starve < STARVE_MAX);
  assign w_cpu_win  = w_run & ~w_play_win & w_cpu_pend;

  assign w_cpu_addr  = ADDR_W'(compose_addr(cpu_ch, IDX_W_MAX'(cpu_idx), WAVE_BITS));
  assign w_play_addr = ADDR_W'(compose_addr(play_ch, IDX_W_MAX'(play_idx), WAVE_BITS));

  // Out-of-range channels never touch the array; their data is forced to 0 on output.
  always_comb begin
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = w_cpu_addr;
    w_ram_d    = cpu_d;
    if (w_sweep) begin
      w_ram_en   = 1'b1;
      w_ram_we   = 1'b1;
      w_ram_addr = r_clr_addr;
      w_ram_d    = '0;
    end else if (w_play_win) begin
      w_ram_en   = ~w_play_oor;
      w_ram_addr = w_play_addr;
    end else if (w_cpu_win) begin
      w_ram_en   = ~w_cpu_oor;
      w_ram_we   = cpu_we;
    end
  end

  wts_wave_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_d    (w_ram_d),
    .o_q    (w_ram_q)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_done       <= 1'b0;
      r_starve     <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_rd     <= 1'b0;
      r_cpu_zero   <= 1'b0;
      r_play_valid <= 1'b0;
      r_play_zero  <= 1'b0;
      r_cpu_q      <= '0;
      r_play_q     <= '0;
    end else begin
      r_done       <= cpu_req & (r_done | w_cpu_win);
      if (w_play_win & w_cpu_pend) begin
        r_starve <= r_starve + STARVE_W'(1);
      end else if (w_cpu_win | ~w_cpu_pend) begin
        r_starve <= '0;
      end
      r_cpu_ack    <= w_cpu_win;
      r_cpu_rd     <= w_cpu_win & ~cpu_we;
      r_cpu_zero   <= w_cpu_oor;
      r_play_valid <= w_play_win;
      r_play_zero  <= w_play_oor;
      if (r_cpu_rd)     r_cpu_q  <= cpu_q;
      if (r_play_valid) r_play_q <= play_q;
    end
  end

  // Read data comes straight from the RAM register on the update cycle, then is held.
  assign cpu_ack    = r_cpu_ack;
  assign cpu_q      = r_cpu_rd ? (r_cpu_zero ? '0 : w_ram_q) : r_cpu_q;
  assign play_valid = r_play_valid;
  assign play_q     = r_play_valid ? (r_play_zero ? '0 : w_ram_q) : r_play_q;

endmodule
